// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch controller: FSM state encoding,
// the sequential PC increment and the word-alignment helper used on every
// address that leaves or enters the fetch unit.
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2
    } state_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the fetch controller's three bus groups:
//   redirect : redirect_valid, redirect_pc              (core -> fetch)
//   imem     : imem_req, imem_addr / imem_ack, imem_rdata
//   decode   : dec_valid, dec_instr, dec_pc / dec_ready
// master = fetch controller side, slave = surrounding core / memory side.
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, dec_ready,
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, dec_ready,
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// QDEPTH-entry 64-bit FIFO holding {pc, instr} pairs between fetch and decode.
// The head entry is presented from registers so decode sees no RAM read path.
//   clk, reset  : clock, asynchronous active-low reset
//   push, push_data : write one entry (caller never pushes when full)
//   pop         : consume head (ignored while empty)
//   flush       : drop all entries at this edge; a pop in the same cycle is
//                 still the consumer's acceptance of the current head
//   count       : entries held (before this cycle's pop/push)
//   head_valid, head_data : registered head of queue
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int QDEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [63:0]                 push_data,
    input  logic                        pop,
    input  logic                        flush,
    output logic [$clog2(QDEPTH):0]     count,
    output logic                        head_valid,
    output logic [63:0]                 head_data
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [QDEPTH];
    logic [AW-1:0] rptr, rptr_nxt, wptr, wptr_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_after_pop;
    logic          do_pop, head_valid_nxt;
    logic [63:0]   head_data_nxt;

    always_comb begin
        do_pop        = pop && head_valid;
        rptr_nxt      = rptr + AW'(do_pop);
        wptr_nxt      = wptr + AW'(push);
        cnt_after_pop = cnt - CW'(do_pop);
        cnt_nxt       = cnt_after_pop + CW'(push);
        if (flush) begin
            rptr_nxt = '0;
            wptr_nxt = '0;
            cnt_nxt  = '0;
        end
        head_valid_nxt = (cnt_nxt != '0);
        // When the queue drains to nothing but the incoming entry, that entry
        // is not yet in mem, so it bypasses straight into the head register.
        head_data_nxt  = (cnt_after_pop == '0) ? push_data : mem[rptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr       <= '0;
            wptr       <= '0;
            cnt        <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            rptr       <= rptr_nxt;
            wptr       <= wptr_nxt;
            cnt        <= cnt_nxt;
            head_valid <= head_valid_nxt;
            if (head_valid_nxt) begin
                head_data <= head_data_nxt;
            end
        end
    end

    assign count = cnt;

endmodule

// File: rtl/riscv_adder.sv
// -----------------------------------------------------------------------------
// riscv_adder
// Plain W-bit modular adder shared across the core.
//   a, b : operands
//   sum  : a + b, carry discarded (wraps modulo 2^W)
// -----------------------------------------------------------------------------
module riscv_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequential instruction fetch with redirect support and a small decode queue.
//   clk, reset           : clock, asynchronous active-low reset
//   bus.redirect_*       : taken branch/jump, replaces the fetch stream
//   bus.imem_*           : request/ack fetch port (request held until ack)
//   bus.dec_*            : registered queue head toward decode
// FSM: IDLE (one cycle after reset) -> FETCH; FETCH -> KILL when a redirect
// arrives while a request is outstanding, since an issued request cannot be
// withdrawn; KILL waits for that ack, drops its data, then resumes.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    localparam int CW = $clog2(QDEPTH) + 1;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt, pend_pc, pend_nxt, pc_plus4, redirect_tgt;
    logic [CW-1:0] q_count;
    logic          imem_req_c, q_push, q_flush;
    logic          head_valid;
    logic [63:0]   head_data;

    riscv_adder #(.W(32)) u_pc_inc (
        .a   (pc),
        .b   (PC_INC),
        .sum (pc_plus4)
    );

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_data  ({pc, bus.imem_rdata}),
        .pop        (bus.dec_ready),
        .flush      (q_flush),
        .count      (q_count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign redirect_tgt = word_align(bus.redirect_pc);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend_pc;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (bus.redirect_valid) begin
                    if (!imem_req_c || bus.imem_ack) begin
                        pc_nxt = redirect_tgt;
                    end else begin
                        pend_nxt  = redirect_tgt;
                        state_nxt = KILL;
                    end
                end else if (imem_req_c && bus.imem_ack) begin
                    pc_nxt = pc_plus4;
                end
            end
            KILL: begin
                if (bus.imem_ack) begin
                    // A redirect in the ack cycle is newer than pend_pc.
                    pc_nxt    = bus.redirect_valid ? redirect_tgt : pend_pc;
                    state_nxt = FETCH;
                end else if (bus.redirect_valid) begin
                    pend_nxt = redirect_tgt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_c = 1'b0;
        q_push     = 1'b0;
        q_flush    = 1'b0;
        case (state)
            FETCH: begin
                // Count is taken before this cycle's pop so a push can never
                // land on a full queue.
                imem_req_c = (q_count < CW'(QDEPTH));
                q_push     = imem_req_c && bus.imem_ack && !bus.redirect_valid;
                q_flush    = bus.redirect_valid;
            end
            KILL: begin
                imem_req_c = 1'b1;
                q_flush    = bus.redirect_valid;
            end
            default: ;
        endcase
    end

    assign bus.imem_req  = imem_req_c;
    assign bus.imem_addr = word_align(pc);
    assign bus.dec_valid = head_valid;
    assign bus.dec_pc    = head_data[63:32];
    assign bus.dec_instr = head_data[31:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Scoreboard bench for fetch_ctrl. Each cycle the reference model works out,
// from the fetch rules alone, which {pc, instr} pairs must reach decode and
// which address must be on the fetch port; a separate monitor pops the
// scoreboard whenever decode consumes an entry. A second instance with
// RESET_PC = 0xFFFF_FFFC covers address wrap from reset.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();
    fetch_ctrl_if bus2 ();

    fetch_ctrl #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(QD)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    entry_t      sb[$];
    bit          running     = 1'b0;
    bit          zombie      = 1'b0;
    bit          exp_req     = 1'b0;
    logic [31:0] exp_pc      = RPC;
    logic [31:0] zombie_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch port check (before this cycle's pop is applied)
    always @(negedge clk) begin
        #1;
        if (reset) begin
            exp_req = running && (zombie || sb.size() < QD);
            chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
            chk("imem_addr", bus.imem_addr, zombie ? zombie_addr : exp_pc);
        end else begin
            exp_req = 1'b0;
        end
    end

    // Decode monitor
    always @(negedge clk) begin : mon
        entry_t e;
        #2;
        if (reset) begin
            chk("dec_valid", 32'(bus.dec_valid), 32'(sb.size() != 0));
            if (bus.dec_valid && bus.dec_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dec_pop: got entry pc %08h, expected empty queue at %0t",
                             bus.dec_pc, $time);
                end else begin
                    e = sb.pop_front();
                    chk("dec_pc", bus.dec_pc, e.pc);
                    chk("dec_instr", bus.dec_instr, e.instr);
                end
            end
        end
    end

    // Model update for the coming rising edge
    always @(negedge clk) begin : model
        logic [31:0] tgt;
        #3;
        tgt = bus.redirect_pc & 32'hFFFF_FFFC;
        if (!reset) begin
            running = 1'b0;
            zombie  = 1'b0;
            exp_pc  = RPC;
            sb.delete();
        end else if (!running) begin
            running = 1'b1;
        end else if (zombie) begin
            if (bus.imem_ack) zombie = 1'b0;
            if (bus.redirect_valid) begin
                sb.delete();
                exp_pc = tgt;
            end
        end else if (bus.redirect_valid) begin
            sb.delete();
            if (exp_req && !bus.imem_ack) begin
                zombie      = 1'b1;
                zombie_addr = exp_pc;
            end
            exp_pc = tgt;
        end else if (exp_req && bus.imem_ack) begin
            sb.push_back({exp_pc, bus.imem_rdata});
            exp_pc = exp_pc + 32'd4;
        end
    end

    task automatic cyc(input bit rdy, input bit ack, input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        bus.dec_ready      = rdy;
        bus.imem_ack       = ack;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_rdata     = $urandom;
    endtask

    task automatic do_reset();
        #4;
        reset = 1'b0;
        #1;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RPC);
        running = 1'b0;
        zombie  = 1'b0;
        exp_pc  = RPC;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.dec_ready       = 1'b0;
        bus.imem_ack        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_rdata      = '0;
        bus2.dec_ready      = 1'b1;
        bus2.imem_ack       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.imem_rdata     = 32'h0000_0013;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_imem_req", 32'(bus.imem_req), 32'd0);
        chk("reset_imem_addr", bus.imem_addr, RPC);
        chk("reset_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("reset_dec_instr", bus.dec_instr, 32'd0);
        chk("reset_dec_pc", bus.dec_pc, 32'd0);
        chk("reset_wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);

        // Release; the ack in the IDLE cycle must be ignored
        cyc(1, 1, 0, 0);
        reset = 1'b1;

        // Streaming with wrap instance checked on its first two fetches
        cyc(1, 1, 0, 0);
        #1;
        chk("wrap_req0", 32'(bus2.imem_req), 32'd1);
        chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0);
        #1;
        chk("wrap_req1", 32'(bus2.imem_req), 32'd1);
        chk("wrap_addr1", bus2.imem_addr, 32'h0000_0000);
        repeat (18) cyc(1, 1, 0, 0);

        // Decode stall fills the queue, then resumes, then stalls again
        repeat (6) cyc(0, 1, 0, 0);
        repeat (4) cyc(1, 1, 0, 0);
        repeat (4) cyc(0, 1, 0, 0);
        do_reset();

        // Redirect while a request is outstanding, ack arrives later
        repeat (4) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h0000_0200);
        repeat (2) cyc(1, 0, 0, 0);
        repeat (4) cyc(1, 1, 0, 0);

        // Redirect with ack; redirects during KILL, latest wins
        cyc(1, 1, 1, 32'h0000_0040);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h0000_0123);
        cyc(1, 0, 1, 32'h0000_0080);
        repeat (4) cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 32'h0000_0300);
        cyc(1, 1, 1, 32'h0000_0400);
        repeat (3) cyc(1, 1, 0, 0);

        // Wrap through redirect, unaligned target
        cyc(1, 1, 1, 32'hFFFF_FFFE);
        repeat (4) cyc(1, 1, 0, 0);

        // Reset with a request outstanding
        cyc(0, 0, 0, 0);
        do_reset();

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) == 0,
                ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : 32'($urandom));
        end

        @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
